string_window: RTL and testbench
================================

STRING_WINDOW -- requirements
Module: string_window

Interface
REQ-001 SHALL have parameter BYTES_CNT, default 15: window length in bytes; legal range 2..64.
REQ-002 SHALL have parameter OFFSET_W, default 16: width of the byte-offset output.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data_i  input  8  input stream byte.
REQ-006 SHALL have port valid_i  input  1  data_i and its flags are valid.
REQ-007 SHALL have port sop_i  input  1  the byte is the first byte of a packet.
REQ-008 SHALL have port eop_i  input  1  the byte is the last byte of a packet.
REQ-009 SHALL have port ready_o  output  1  the block accepts a byte this cycle.
REQ-010 SHALL have port string_o  output  BYTES_CNT x 8 (packed [BYTES_CNT-1:0][7:0])  window for the hash stage; index 0 holds the oldest byte.
REQ-011 SHALL have port valid_o  output  1  string_o, offset_o and eop_o are valid.
REQ-012 SHALL have port offset_o  output  OFFSET_W  0-based packet offset of the newest window byte, string_o[BYTES_CNT-1].
REQ-013 SHALL have port eop_o  output  1  the newest window byte carried eop.
REQ-014 SHALL have port ready_i  input  1  the downstream stage consumes the output word this cycle.

Function
REQ-015 SHALL accept a byte when valid_i && ready_o; ready_o = !valid_o || ready_i, combinational.
REQ-016 SHALL implement states IDLE, FILL and RUN, plus a fill counter that runs 0..BYTES_CNT.
REQ-017 SHALL, in IDLE, drop an accepted byte without sop_i: no shift, no state change, no output.
REQ-018 SHALL, for an accepted byte with sop_i in any state: place the byte at shift position BYTES_CNT-1, set fill=1, set offset=0, go to FILL; the previous partial packet is abandoned.
REQ-019 SHALL, for an accepted byte without sop_i in FILL/RUN: shift the window (position k takes k+1; position BYTES_CNT-1 takes data_i), increment fill saturating at BYTES_CNT, increment offset saturating at 2^OFFSET_W-1.
REQ-020 SHALL go from FILL to RUN when fill reaches BYTES_CNT.
REQ-021 SHALL load the output register on the edge after an accepted byte that leaves fill==BYTES_CNT: string_o=window, offset_o=offset, eop_o=eop_i, valid_o=1 (latency 1 cycle).
REQ-022 SHALL, for an accepted byte with eop_i, emit its window per REQ-021 if complete, then go to IDLE with fill=0.
REQ-023 SHALL treat sop_i && eop_i on one byte as a 1-byte packet: no window is emitted and the next state is IDLE.
REQ-024 SHALL hold string_o, offset_o and eop_o stable while valid_o && !ready_i; no byte is accepted and none is lost.
REQ-025 SHALL clear valid_o when ready_i=1 and no window-completing byte is accepted in the same cycle; on simultaneous consume and new window, it loads the new word with valid_o kept at 1, giving full throughput of 1 window per cycle.
REQ-026 SHALL produce no window for a packet shorter than BYTES_CNT bytes.
REQ-027 SHALL emit exactly L-BYTES_CNT+1 windows for a packet of L >= BYTES_CNT bytes, in offset order.

Reset
REQ-028 SHALL, while rst_n_i=0, asynchronously force: state IDLE, fill 0, offset 0, shift register 0, string_o 0, offset_o 0, eop_o 0, valid_o 0; ready_o is therefore 1.
REQ-029 SHALL discard any packet in progress on reset mid-packet; bytes after reset are dropped until the next sop_i.

Verification
REQ-030 SHALL cover: a 20-byte packet of 0x00..0x13 with ready_i=1 -> 6 windows on consecutive cycles; first has string_o[0]=0x00, string_o[14]=0x0E, offset_o=14; last has string_o[0]=0x05, offset_o=19, eop_o=1.
REQ-031 SHALL cover: a 10-byte packet -> valid_o never asserted and the state returns to IDLE.
REQ-032 SHALL cover: ready_i=0 for 3 cycles during the 20-byte packet -> ready_o=0, string_o stable, all 6 windows still delivered in order.
REQ-033 SHALL cover: sop after 8 bytes, then a 15-byte packet 0xA0..0xAE -> exactly one window, string_o[0]=0xA0, offset_o=14, eop_o=1.
REQ-034 SHALL cover: 5 bytes without sop in IDLE, then a 15-byte packet -> the 5 bytes are dropped and one window is emitted, containing only packet bytes.
REQ-035 SHALL cover: rst_n_i pulsed low after byte 16 of the 20-byte packet -> valid_o=0 immediately; the remaining 4 bytes are dropped.

Source files
------------

// File: rtl/string_window.sv
// Sliding byte window over a packetised stream: emits one BYTES_CNT-byte window per
// accepted byte once a packet has supplied enough bytes, with the newest byte's packet offset.
module string_window #(
  parameter int BYTES_CNT = 15,
  parameter int OFFSET_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [7:0]                data_i,
  input  logic                      valid_i,
  input  logic                      sop_i,
  input  logic                      eop_i,
  output logic                      ready_o,
  output logic [BYTES_CNT-1:0][7:0] string_o,
  output logic                      valid_o,
  output logic [OFFSET_W-1:0]       offset_o,
  output logic                      eop_o,
  input  logic                      ready_i
);

  localparam int FILL_W = $clog2(BYTES_CNT + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                    state_p0;
  logic [FILL_W-1:0]         fill_p0;
  logic [OFFSET_W-1:0]       offset_p0;
  logic [BYTES_CNT-1:0][7:0] win_p0;

  logic                      accept;
  logic                      shift_en;
  logic                      emit;
  logic [FILL_W-1:0]         fill_nxt;
  logic [OFFSET_W-1:0]       offset_nxt;
  logic [BYTES_CNT-1:0][7:0] win_nxt;

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_W'(BYTES_CNT)) ? f : f + 1'b1;
  endfunction

  function automatic logic [OFFSET_W-1:0] offset_inc(input logic [OFFSET_W-1:0] o);
    return (&o) ? o : o + 1'b1;
  endfunction

  assign ready_o  = !valid_o || ready_i;
  assign accept   = valid_i && ready_o;
  // Outside a packet only a sop byte is taken into the window.
  assign shift_en = accept && (sop_i || (state_p0 != IDLE));
  assign emit     = shift_en && !sop_i && (fill_nxt == FILL_W'(BYTES_CNT));

  always_comb begin
    for (int k = 0; k < BYTES_CNT - 1; k++) begin
      win_nxt[k] = win_p0[k+1];
    end
    win_nxt[BYTES_CNT-1] = data_i;
    fill_nxt   = sop_i ? FILL_W'(1) : fill_inc(fill_p0);
    offset_nxt = sop_i ? '0 : offset_inc(offset_p0);
  end

  // Stage p0 -> output register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_p0  <= IDLE;
      fill_p0   <= '0;
      offset_p0 <= '0;
      win_p0    <= '0;
      string_o  <= '0;
      offset_o  <= '0;
      eop_o     <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      if (shift_en) begin
        win_p0    <= win_nxt;
        offset_p0 <= offset_nxt;
        if (eop_i) begin
          state_p0 <= IDLE;
          fill_p0  <= '0;
        end else begin
          fill_p0  <= fill_nxt;
          state_p0 <= (fill_nxt == FILL_W'(BYTES_CNT)) ? RUN : FILL;
        end
      end
      if (emit) begin
        string_o <= win_nxt;
        offset_o <= offset_nxt;
        eop_o    <= eop_i;
        valid_o  <= 1'b1;
      end else if (ready_i) begin
        valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_string_window.sv
// Bench for string_window: directed packet scenarios plus randomized traffic,
// checked by a scoreboard fed from a packet-level reference model.
module tb_string_window;

  localparam int BC     = 15;
  localparam int OW     = 5;
  localparam int MAXOFF = (1 << OW) - 1;

  logic                clk_i;
  logic                rst_n_i;
  logic [7:0]          data_i;
  logic                valid_i;
  logic                sop_i;
  logic                eop_i;
  logic                ready_o;
  logic [BC-1:0][7:0]  string_o;
  logic                valid_o;
  logic [OW-1:0]       offset_o;
  logic                eop_o;
  logic                ready_i;

  string_window #(.BYTES_CNT(BC), .OFFSET_W(OW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .ready_o(ready_o), .string_o(string_o),
    .valid_o(valid_o), .offset_o(offset_o), .eop_o(eop_o), .ready_i(ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [BC-1:0][7:0] s;
    logic [OW-1:0]      off;
    logic               e;
  } win_t;

  win_t       exp_q[$];
  logic [7:0] hist[$];
  int         pcnt;
  bit         active;
  int         tests = 0;
  int         fails = 0;
  int         win_cnt = 0;
  bit         hold_chk = 0;
  win_t       held;
  bit         rand_ready;
  int         stall_cnt;

  // Monitor first (pops words consumed at the coming edge), then reference model.
  always @(negedge clk_i) begin
    win_t got, w;
    got = {string_o, offset_o, eop_o};
    if (hold_chk && rst_n_i) begin
      tests++;
      if (!valid_o || got != held) begin
        fails++;
        $display("FAIL hold: got v=%0d s=%h off=%0d eop=%0d, want v=1 s=%h off=%0d eop=%0d",
                 valid_o, got.s, got.off, got.e, held.s, held.off, held.e);
      end
    end
    hold_chk = 0;
    if (rst_n_i && valid_o) begin
      if (ready_i) begin
        tests++;
        win_cnt++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL window: got unexpected s=%h off=%0d eop=%0d, want none",
                   got.s, got.off, got.e);
        end else begin
          w = exp_q.pop_front();
          if (got != w) begin
            fails++;
            $display("FAIL window: got s=%h off=%0d eop=%0d, want s=%h off=%0d eop=%0d",
                     got.s, got.off, got.e, w.s, w.off, w.e);
          end
        end
      end else begin
        hold_chk = 1;
        held     = got;
      end
    end

    if (!rst_n_i) begin
      exp_q.delete();
      hist.delete();
      pcnt   = 0;
      active = 0;
    end else if (valid_i && ready_o) begin
      if (sop_i) begin
        hist.delete();
        hist.push_back(data_i);
        pcnt   = 1;
        active = !eop_i;
      end else if (active) begin
        hist.push_back(data_i);
        if (hist.size() > BC) void'(hist.pop_front());
        pcnt++;
        if (pcnt >= BC) begin
          for (int k = 0; k < BC; k++) w.s[k] = hist[k];
          w.off = (pcnt - 1 > MAXOFF) ? OW'(MAXOFF) : OW'(pcnt - 1);
          w.e   = eop_i;
          exp_q.push_back(w);
        end
        if (eop_i) active = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    if (stall_cnt > 0) begin
      ready_i = 1'b0;
      stall_cnt--;
    end else begin
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    bit acc;
    int tries;
    valid_i = 1'b1;
    data_i  = d;
    sop_i   = s;
    eop_i   = e;
    acc     = 0;
    tries   = 0;
    while (!acc && tries < 100) begin
      @(negedge clk_i);
      acc = ready_o;
      next_cycle();
      tries++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready_o=0 for %0d cycles, want 1", tries);
    end
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] start, input int len);
    for (int i = 0; i < len; i++) send(start + 8'(i), i == 0, i == len - 1);
  endtask

  task automatic drain();
    int n;
    rand_ready = 0;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 200) begin
      next_cycle();
      n++;
    end
    next_cycle();
    tests++;
    if (exp_q.size() != 0 || valid_o) begin
      fails++;
      $display("FAIL drain: got %0d pending, valid_o=%0d, want 0 pending", exp_q.size(), valid_o);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d windows, want %0d", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0b, want %0b", name, got, want);
    end
  endtask

  initial begin
    int base, len, cut;
    rst_n_i = 1'b0; data_i = '0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    ready_i = 1'b1; rand_ready = 0; stall_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_bit("rst_valid_o", valid_o, 1'b0);
    check_bit("rst_ready_o", ready_o, 1'b1);
    check_bit("rst_eop_o", eop_o, 1'b0);
    check_bit("rst_string_zero", string_o == '0, 1'b1);
    check_bit("rst_offset_zero", offset_o == '0, 1'b1);
    rst_n_i = 1'b1;
    next_cycle();

    base = win_cnt; send_pkt(8'h00, 20); drain();
    check_cnt("pkt20_windows", win_cnt - base, 6);

    base = win_cnt; send_pkt(8'h40, 10); drain();
    check_cnt("pkt10_windows", win_cnt - base, 0);

    base = win_cnt;
    for (int i = 0; i < 16; i++) send(8'(i), i == 0, 1'b0);
    ready_i   = 1'b0;
    stall_cnt = 2;
    @(negedge clk_i);
    check_bit("stall_ready_o", ready_o, 1'b0);
    check_bit("stall_valid_o", valid_o, 1'b1);
    next_cycle();
    for (int i = 16; i < 20; i++) send(8'(i), 1'b0, i == 19);
    drain();
    check_cnt("stall_windows", win_cnt - base, 6);

    base = win_cnt;
    for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), i == 0, 1'b0);
    send_pkt(8'hA0, 15); drain();
    check_cnt("resop_windows", win_cnt - base, 1);

    base = win_cnt;
    for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i), 1'b0, 1'b0);
    send_pkt(8'h30, 15); drain();
    check_cnt("nosop_windows", win_cnt - base, 1);

    base = win_cnt;
    for (int i = 0; i < 16; i++) send(8'(i), i == 0, 1'b0);
    rst_n_i = 1'b0;
    #1;
    check_bit("midrst_valid_o", valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    for (int i = 16; i < 20; i++) send(8'(i), 1'b0, i == 19);
    drain();
    check_cnt("midrst_windows", win_cnt - base, 1);

    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 7) == 0) send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      len = $urandom_range(1, 45);
      cut = ($urandom_range(0, 5) == 0) ? 1 : 0;
      for (int i = 0; i < len; i++) begin
        send(8'($urandom), i == 0, (i == len - 1) && !cut);
        if ($urandom_range(0, 5) == 0) begin
          valid_i = 1'b0;
          repeat ($urandom_range(1, 3)) next_cycle();
        end
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
